// File: rtl/logic_gates_checker_if.sv
// Signal bundle between the gate-stage stimulus source and logic_gates_checker.
// The master drives stimulus and gate responses; the checker (slave) returns run statistics.
interface logic_gates_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             iStart;
  logic             iValid;
  logic             iA;
  logic             iB;
  logic             iAnd;
  logic             iOr;
  logic             iNot;
  logic             oBusy;
  logic             oDone;
  logic             oPass;
  logic [CNT_W-1:0] oVecCnt;
  logic [CNT_W-1:0] oErrCnt;
  logic [CNT_W-1:0] oFirstErrIdx;
  logic [2:0]       oErrMask;

  modport master (
    output iStart, iValid, iA, iB, iAnd, iOr, iNot,
    input  oBusy, oDone, oPass, oVecCnt, oErrCnt, oFirstErrIdx, oErrMask
  );

  modport slave (
    input  iStart, iValid, iA, iB, iAnd, iOr, iNot,
    output oBusy, oDone, oPass, oVecCnt, oErrCnt, oFirstErrIdx, oErrMask
  );
endinterface

// File: rtl/logic_gates_checker.sv
// Self-checker for a two-input AND/OR/NOT gate stage: compares each valid sample
// against golden values and accumulates run statistics over NUM_VECTORS samples.
module logic_gates_checker #(
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  iClk,
  input  logic                  iRst,
  logic_gates_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_NUM_VEC = CNT_W'(NUM_VECTORS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_vec_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_first_idx;
  logic [2:0]       r_err_mask;
  logic [CNT_W-1:0] w_vec_cnt_nxt;
  logic [CNT_W-1:0] w_err_cnt_nxt;
  logic [CNT_W-1:0] w_first_idx_nxt;
  logic [2:0]       w_err_mask_nxt;
  logic [CNT_W-1:0] w_vec_inc;
  logic [2:0]       w_mismatch;
  logic             w_fail;

  assign w_mismatch[0] = bus.iAnd != (bus.iA & bus.iB);
  assign w_mismatch[1] = bus.iOr  != (bus.iA | bus.iB);
  assign w_mismatch[2] = bus.iNot != ~bus.iA;
  assign w_fail        = |w_mismatch;
  assign w_vec_inc     = r_vec_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_vec_cnt_nxt   = r_vec_cnt;
    w_err_cnt_nxt   = r_err_cnt;
    w_first_idx_nxt = r_first_idx;
    w_err_mask_nxt  = r_err_mask;
    case (r_state)
      IDLE, DONE: begin
        // A start here always wins; a coincident valid sample is dropped.
        if (bus.iStart) begin
          w_state_nxt     = RUN;
          w_vec_cnt_nxt   = '0;
          w_err_cnt_nxt   = '0;
          w_first_idx_nxt = '1;
          w_err_mask_nxt  = '0;
        end
      end
      RUN: begin
        if (bus.iValid) begin
          w_vec_cnt_nxt = w_vec_inc;
          if (w_fail) begin
            if (r_err_cnt != '1) begin
              w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
            end
            w_err_mask_nxt = r_err_mask | w_mismatch;
            if (r_first_idx == '1) begin
              w_first_idx_nxt = r_vec_cnt;
            end
          end
          if (w_vec_inc == LP_NUM_VEC) begin
            w_state_nxt = DONE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state     <= IDLE;
      r_vec_cnt   <= '0;
      r_err_cnt   <= '0;
      r_first_idx <= '1;
      r_err_mask  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_vec_cnt   <= w_vec_cnt_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_first_idx <= w_first_idx_nxt;
      r_err_mask  <= w_err_mask_nxt;
    end
  end

  // Status flags decode only registered state, so no input reaches an output combinationally.
  assign bus.oBusy        = (r_state == RUN);
  assign bus.oDone        = (r_state == DONE);
  assign bus.oPass        = (r_state == DONE) && (r_err_cnt == '0);
  assign bus.oVecCnt      = r_vec_cnt;
  assign bus.oErrCnt      = r_err_cnt;
  assign bus.oFirstErrIdx = r_first_idx;
  assign bus.oErrMask     = r_err_mask;

endmodule

// File: doc/logic_gates_checker.md
Name: logic_gates_checker

Overview:
- Downstream consumer of the two-input gate stage.
- Samples the stimulus (iA, iB) and the gate responses (AND, OR, NOT) on valid strobes, and compares each response against an internally computed golden value.
- Accumulates vector, error and first-failure statistics over a run of NUM_VECTORS samples, then reports pass/fail.
- Used on-board and in simulation to self-check the gate stage without manual waveform inspection.

Parameters:
- NUM_VECTORS, default 4: number of valid samples per run. Legal range 1 .. 2^CNT_W-2.
- CNT_W, default 8: width of all counters and index outputs.

Ports:
- iClk  input  1  system clock; all state updates on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iStart  input  1  single-cycle pulse; begins a new run (honoured in IDLE and DONE only).
- iValid  input  1  sample strobe; the five data inputs are meaningful only when high.
- iA  input  1  stimulus operand A, as driven to the gate stage.
- iB  input  1  stimulus operand B, as driven to the gate stage.
- iAnd  input  1  gate stage AND result.
- iOr  input  1  gate stage OR result.
- iNot  input  1  gate stage NOT result (NOT of A).
- oBusy  output  1  high while in RUN.
- oDone  output  1  high while in DONE.
- oPass  output  1  high in DONE when oErrCnt == 0; low otherwise.
- oVecCnt  output  CNT_W  valid samples accepted in the current/last run.
- oErrCnt  output  CNT_W  failing samples; saturates at all-ones.
- oFirstErrIdx  output  CNT_W  0-based index of the first failing sample; all-ones if none.
- oErrMask  output  3  sticky per-output failure flags: bit0 AND, bit1 OR, bit2 NOT.

Behaviour:
- Reset (iRst=1 at rising edge, any state, including mid-run):
  - state is IDLE.
  - oBusy=0, oDone=0, oPass=0, oVecCnt=0, oErrCnt=0, oErrMask=0.
  - oFirstErrIdx=all-ones.
  - Reset overrides iStart and iValid in the same cycle.
- Golden values: expAnd = iA & iB, expOr = iA | iB, expNot = ~iA.
- Sample fail: any of iAnd/iOr/iNot differs from its golden value.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - iValid ignored.
  - iStart=1 -> RUN. On the same edge: oVecCnt=0, oErrCnt=0, oErrMask=0, oFirstErrIdx=all-ones.
- RUN:
  - Each cycle with iValid=1 is one accepted sample: oVecCnt increments.
  - On a failing sample:
    - oErrCnt increments, holding at all-ones if already saturated.
    - oErrMask |= the per-output mismatch bits.
    - If oFirstErrIdx is all-ones, it is loaded with the pre-increment oVecCnt.
  - Cycles with iValid=0 change nothing.
  - iStart is ignored in RUN.
  - When the accepted sample makes oVecCnt == NUM_VECTORS -> DONE on that edge, with statistics including that sample.
- DONE:
  - All statistics frozen; iValid ignored.
  - oPass = (oErrCnt == 0).
  - iStart=1 -> RUN with the same clears as from IDLE. oDone and oPass drop on that edge.
- Latency: statistics reflect a sample one cycle after the edge at which it is captured.
- oDone asserts on the clock edge that captures the last sample.
- All outputs are registered; no combinational input-to-output path.
- Simultaneous iStart and iValid in IDLE/DONE: start is taken, the sample is discarded, and counters are cleared.

Test Plan:
- Good stage, all four combos (A,B) = 00, 10, 01, 11 on consecutive iValid cycles after iStart -> oDone=1 one cycle after the 4th sample. Required: oPass=1, oVecCnt=4, oErrCnt=0, oErrMask=000, oFirstErrIdx=8'hFF, oBusy=0.
- AND stuck-at-0: same sequence, iAnd=0 at A=1,B=1 (index 3) -> oPass=0, oErrCnt=1, oFirstErrIdx=3, oErrMask=001.
- NOT inverted on all vectors plus OR wrong at index 1 -> oErrCnt=4, oFirstErrIdx=0, oErrMask=110.
- iValid gaps: four samples interleaved with 3 idle cycles each -> oVecCnt steps only on valid cycles. oDone is reached after the 4th valid sample, never earlier. iStart pulsed mid-run has no effect.
- Restart from DONE after a failed run: iStart with iValid=1 in the same cycle -> that sample is dropped. Counters and oErrMask clear, and oFirstErrIdx returns to 8'hFF. A subsequent clean run ends with oPass=1, oVecCnt=4.
- Reset mid-run after 2 samples with 1 error: iRst=1 for one cycle -> all outputs return to reset values next edge and state is IDLE. iValid with no iStart then leaves oVecCnt=0.
